// File: rtl/gamepad_wb.sv
// gamepad_wb: Wishbone-lite poller for serial (latch/clock/data) game controllers.
// Define GAMEPAD_MULTITAP_EN to scan a second bank (pads 2/3) selected through gp_sel.
module gamepad_wb #(
    parameter int unsigned DIV     = 8,
    parameter int unsigned POLL_TW = 18
) (
    input  logic        clk,
    input  logic        rst,
    output logic        gp_latch,
    output logic        gp_clk,
    output logic        gp_sel,
    input  logic [1:0]  gp_data,
    input  logic [1:0]  wb_addr,
    input  logic [31:0] wb_wdata,
    output logic [31:0] wb_rdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack
);

    typedef enum logic [2:0] {IDLE, LATCH, GAP, LOW, HIGH, DONE} state_t;

    localparam logic [8:0] LD_LATCH = 9'(2 * DIV - 1);
    localparam logic [8:0] LD_PHASE = 9'(DIV - 1);

    state_t              r_state;
    logic [8:0]          r_cnt;
    logic [3:0]          r_bit;
    logic                r_latch;
    logic                r_gpclk;
    logic [15:0]         r_sh0;
    logic [15:0]         r_sh1;
    logic [15:0]         r_pad0;
    logic [15:0]         r_pad1;
    logic [15:0]         r_scan_cnt;
    logic                r_autopoll;
    logic [POLL_TW-1:0]  r_poll;
    logic                r_ack;
    logic [31:0]         r_rdata;
`ifdef GAMEPAD_MULTITAP_EN
    logic                r_sel;
    logic                r_pass;
    logic [15:0]         r_sh2;
    logic [15:0]         r_sh3;
    logic [15:0]         r_pad2;
    logic [15:0]         r_pad3;
`endif

    logic                w_req;
    logic                w_trig;
    logic                w_tick;
    logic                w_busy;
    logic                w_sample;
    logic [31:0]         w_rd;
    logic                w_unused;

    assign w_req    = wb_cyc & ~r_ack;
    assign w_trig   = w_req & wb_we & (wb_addr == 2'd0) & wb_wdata[2];
    assign w_tick   = r_autopoll & (&r_poll);
    assign w_busy   = (r_state != IDLE);
    assign w_sample = ((r_state == GAP) || (r_state == HIGH)) && (r_cnt == 9'd0);
    assign w_unused = &{1'b0, wb_wdata[31:3], wb_wdata[1]};

    assign gp_latch = r_latch;
    assign gp_clk   = r_gpclk;
    assign wb_ack   = r_ack;
    assign wb_rdata = r_rdata;
`ifdef GAMEPAD_MULTITAP_EN
    assign gp_sel   = r_sel;
`else
    assign gp_sel   = 1'b0;
`endif

    always_comb begin
        w_rd = '0;
        case (wb_addr)
            2'd0:    w_rd = {29'd0, 1'b0, w_busy, r_autopoll};
            2'd1:    w_rd = {r_pad1, r_pad0};
`ifdef GAMEPAD_MULTITAP_EN
            2'd2:    w_rd = {r_pad3, r_pad2};
`else
            2'd2:    w_rd = '0;
`endif
            default: w_rd = {16'd0, r_scan_cnt};
        endcase
    end

    // Bus: one-cycle ack per request; read data is zero outside the ack cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack      <= 1'b0;
            r_rdata    <= '0;
            r_autopoll <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_req ? w_rd : '0;
            if (w_req && wb_we && (wb_addr == 2'd0))
                r_autopoll <= wb_wdata[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_poll <= '0;
        else
            r_poll <= r_poll + {{(POLL_TW-1){1'b0}}, 1'b1};
    end

    // Pad lines are active-low; shifting in from the top leaves button k at bit k.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh0 <= '0;
            r_sh1 <= '0;
`ifdef GAMEPAD_MULTITAP_EN
            r_sh2 <= '0;
            r_sh3 <= '0;
`endif
        end else if (w_sample) begin
`ifdef GAMEPAD_MULTITAP_EN
            if (r_pass) begin
                r_sh2 <= {~gp_data[0], r_sh2[15:1]};
                r_sh3 <= {~gp_data[1], r_sh3[15:1]};
            end else begin
                r_sh0 <= {~gp_data[0], r_sh0[15:1]};
                r_sh1 <= {~gp_data[1], r_sh1[15:1]};
            end
`else
            r_sh0 <= {~gp_data[0], r_sh0[15:1]};
            r_sh1 <= {~gp_data[1], r_sh1[15:1]};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_latch    <= 1'b0;
            r_gpclk    <= 1'b1;
            r_pad0     <= '0;
            r_pad1     <= '0;
            r_scan_cnt <= '0;
`ifdef GAMEPAD_MULTITAP_EN
            r_sel      <= 1'b0;
            r_pass     <= 1'b0;
            r_pad2     <= '0;
            r_pad3     <= '0;
`endif
        end else begin
            if (r_cnt != 9'd0)
                r_cnt <= r_cnt - 9'd1;
            case (r_state)
                IDLE: begin
                    if (w_trig || w_tick) begin
                        r_state <= LATCH;
                        r_latch <= 1'b1;
                        r_cnt   <= LD_LATCH;
                        r_bit   <= '0;
`ifdef GAMEPAD_MULTITAP_EN
                        r_sel   <= 1'b0;
                        r_pass  <= 1'b0;
`endif
                    end
                end
                LATCH: begin
                    if (r_cnt == 9'd0) begin
                        r_state <= GAP;
                        r_latch <= 1'b0;
                        r_cnt   <= LD_PHASE;
                    end
                end
                GAP: begin
                    if (r_cnt == 9'd0) begin
                        r_state <= LOW;
                        r_gpclk <= 1'b0;
                        r_cnt   <= LD_PHASE;
                        r_bit   <= 4'd1;
                    end
                end
                LOW: begin
                    if (r_cnt == 9'd0) begin
                        r_state <= HIGH;
                        r_gpclk <= 1'b1;
                        r_cnt   <= LD_PHASE;
                    end
                end
                HIGH: begin
                    if (r_cnt == 9'd0) begin
                        if (r_bit == 4'd15) begin
`ifdef GAMEPAD_MULTITAP_EN
                            // Second bank starts straight away; sel flips on the edge latch rises.
                            if (!r_pass) begin
                                r_state <= LATCH;
                                r_latch <= 1'b1;
                                r_cnt   <= LD_LATCH;
                                r_bit   <= '0;
                                r_sel   <= 1'b1;
                                r_pass  <= 1'b1;
                            end else begin
                                r_state <= DONE;
                            end
`else
                            r_state <= DONE;
`endif
                        end else begin
                            r_state <= LOW;
                            r_gpclk <= 1'b0;
                            r_cnt   <= LD_PHASE;
                            r_bit   <= r_bit + 4'd1;
                        end
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_pad0     <= r_sh0;
                    r_pad1     <= r_sh1;
                    r_scan_cnt <= r_scan_cnt + 16'd1;
`ifdef GAMEPAD_MULTITAP_EN
                    r_pad2     <= r_sh2;
                    r_pad3     <= r_sh3;
                    r_sel      <= 1'b0;
                    r_pass     <= 1'b0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gamepad_wb.sv
// tb_gamepad_wb: directed bench for gamepad_wb with a shift-register pad model.
// Honors GAMEPAD_MULTITAP_EN the same way as the design.
module tb_gamepad_wb;

    localparam int unsigned DIV     = 4;
    localparam int unsigned POLL_TW = 8;
`ifdef GAMEPAD_MULTITAP_EN
    localparam int unsigned NPASS   = 2;
`else
    localparam int unsigned NPASS   = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gp_latch;
    logic        gp_clk;
    logic        gp_sel;
    logic [1:0]  gp_data;
    logic [1:0]  wb_addr = '0;
    logic [31:0] wb_wdata = '0;
    logic [31:0] wb_rdata;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_ack;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    gamepad_wb #(.DIV(DIV), .POLL_TW(POLL_TW)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .gp_latch (gp_latch),
        .gp_clk   (gp_clk),
        .gp_sel   (gp_sel),
        .gp_data  (gp_data),
        .wb_addr  (wb_addr),
        .wb_wdata (wb_wdata),
        .wb_rdata (wb_rdata),
        .wb_we    (wb_we),
        .wb_cyc   (wb_cyc),
        .wb_ack   (wb_ack)
    );

    always #5 clk = ~clk;

    // Pad model: raw line words (0 = pressed), latch reloads, gp_clk rise advances.
    logic [15:0] raw [0:3];
    int unsigned sh_idx = 0;
    always @(posedge gp_clk or posedge gp_latch) begin
        if (gp_latch) sh_idx <= 0;
        else          sh_idx <= sh_idx + 1;
    end
    assign gp_data = (sh_idx < 16) ? {raw[{gp_sel, 1'b1}][sh_idx[3:0]],
                                      raw[{gp_sel, 1'b0}][sh_idx[3:0]]} : 2'b11;

    int unsigned m_cyc = 0, m_lhi = 0, m_lrise = 0, m_crise = 0;
    int unsigned m_t_lr = 0, m_t_lr_prev = 0, m_t_cr = 0, m_selhi = 0, m_selbad = 0;
    logic m_sel_lr = 1'b0, m_sel_lr_prev = 1'b0;
    logic p_latch = 1'b0, p_clk = 1'b1, p_sel = 1'b0;
    always @(negedge clk) begin
        m_cyc++;
        if (gp_latch) m_lhi++;
        if (gp_latch && !p_latch) begin
            m_lrise++;
            m_t_lr_prev   = m_t_lr;
            m_t_lr        = m_cyc;
            m_sel_lr_prev = m_sel_lr;
            m_sel_lr      = gp_sel;
        end
        if (gp_clk && !p_clk) begin
            m_crise++;
            m_t_cr = m_cyc;
        end
        if (gp_sel) m_selhi++;
        if ((gp_sel !== p_sel) && gp_latch && p_latch) m_selbad++;
        p_latch = gp_latch;
        p_clk   = gp_clk;
        p_sel   = gp_sel;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd,
                           output logic [31:0] d);
        logic ok;
        ok = 1'b0;
        d  = '0;
        @(negedge clk);
        wb_addr  = a;
        wb_we    = we;
        wb_wdata = wd;
        wb_cyc   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wb_ack) begin
                ok = 1'b1;
                d  = wb_rdata;
                break;
            end
        end
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
        if (!ok) check("wb_ack_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] d);
        wb_xfer(1'b0, a, '0, d);
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, wd, dummy);
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        logic        done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            wb_rd(2'd0, d);
            if (d[1] == 1'b0) done = 1'b1;
        end
        check("scan_completes", {31'd0, done}, 32'd1);
    endtask

    logic [31:0] rd;
    int unsigned b_lhi, b_lrise, b_crise;
    logic        reached;

    task automatic snap();
        #1;
        b_lhi   = m_lhi;
        b_lrise = m_lrise;
        b_crise = m_crise;
    endtask

    initial begin
        raw[0] = 16'hFFFF; raw[1] = 16'hFFFF; raw[2] = 16'hFFFF; raw[3] = 16'hFFFF;

        // Reset state
        do_reset();
        #1;
        check("rst_gp_clk", {31'd0, gp_clk}, 32'd1);
        check("rst_gp_latch", {31'd0, gp_latch}, 32'd0);
        check("rst_gp_sel", {31'd0, gp_sel}, 32'd0);
        check("rst_wb_ack", {31'd0, wb_ack}, 32'd0);
        check("rst_wb_rdata", wb_rdata, 32'd0);
        wb_rd(2'd0, rd); check("rst_csr", rd, 32'h0000_0000);
        wb_rd(2'd1, rd); check("rst_pads01", rd, 32'h0000_0000);
        wb_rd(2'd3, rd); check("rst_scan_cnt", rd, 32'h0000_0000);

        // Single software-triggered scan
        raw[0] = 16'hFFFE; raw[1] = 16'h7FFF; raw[2] = 16'hFFF0; raw[3] = 16'h0FFF;
        snap();
        wb_wr(2'd0, 32'h4);
        wait_idle();
        check("latch_cycles", m_lhi - b_lhi, 8 * NPASS);
        check("latch_pulses", m_lrise - b_lrise, NPASS);
        check("clk_rises", m_crise - b_crise, 15 * NPASS);
`ifdef GAMEPAD_MULTITAP_EN
        check("scan_span", m_t_cr - m_t_lr_prev + DIV + 1, 32'd265);
        check("sel_pass0", {31'd0, m_sel_lr_prev}, 32'd0);
        check("sel_pass1", {31'd0, m_sel_lr}, 32'd1);
        wb_rd(2'd2, rd); check("pads23", rd, 32'hF000_000F);
`else
        check("scan_span", m_t_cr - m_t_lr + DIV, 32'd132);
        check("sel_held_low", m_selhi, 32'd0);
        wb_rd(2'd2, rd); check("pads23_absent", rd, 32'h0000_0000);
`endif
        check("sel_stable_in_latch", m_selbad, 32'd0);
        wb_rd(2'd1, rd); check("pads01", rd, 32'h8000_0001);
        wb_rd(2'd3, rd); check("scan_cnt_1", rd, 32'd1);
        wb_rd(2'd0, rd); check("csr_after_scan", rd, 32'h0000_0000);

        // Writes to read-only registers are acked and ignored
        wb_wr(2'd1, 32'hDEAD_BEEF);
        wb_wr(2'd3, 32'hFFFF_FFFF);
        wb_rd(2'd1, rd); check("ro_pads01", rd, 32'h8000_0001);
        wb_rd(2'd3, rd); check("ro_scan_cnt", rd, 32'd1);
        @(negedge clk);
        check("rdata_zero_idle", wb_rdata, 32'd0);

        // Held cyc: ack one cycle after rise, never on consecutive cycles
        wb_addr = 2'd1; wb_we = 1'b0; wb_cyc = 1'b1;
        @(negedge clk); check("ack_first", {31'd0, wb_ack}, 32'd1);
        check("ack_first_data", wb_rdata, 32'h8000_0001);
        @(negedge clk); check("ack_gap", {31'd0, wb_ack}, 32'd0);
        check("ack_gap_data", wb_rdata, 32'd0);
        wb_cyc = 1'b0;

        // Second pattern
        raw[0] = 16'h5A5A; raw[1] = 16'h0000;
        wb_wr(2'd0, 32'h4);
        wait_idle();
        wb_rd(2'd1, rd); check("pads01_pat2", rd, 32'hFFFF_A5A5);
        wb_rd(2'd3, rd); check("scan_cnt_2", rd, 32'd2);

        // Trigger while busy is dropped
        do_reset();
        raw[0] = 16'hFFFE; raw[1] = 16'h7FFF;
        snap();
        wb_wr(2'd0, 32'h4);
        repeat (9) @(negedge clk);
        wb_wr(2'd0, 32'h4);
        wb_rd(2'd0, rd); check("busy_mid_scan", rd, 32'h0000_0002);
        wait_idle();
        repeat (300) @(negedge clk);
        wb_rd(2'd3, rd); check("drop_scan_cnt", rd, 32'd1);
        check("drop_latch_pulses", m_lrise - b_lrise, NPASS);

        // Reset in the middle of bit 7
        do_reset();
        raw[0] = 16'h0000; raw[1] = 16'h0000;
        snap();
        wb_wr(2'd0, 32'h4);
        reached = 1'b0;
        for (int i = 0; i < 400 && !reached; i++) begin
            @(negedge clk); #1;
            if (m_crise - b_crise >= 7) reached = 1'b1;
        end
        check("reach_bit7", {31'd0, reached}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_gp_clk", {31'd0, gp_clk}, 32'd1);
        check("abort_gp_latch", {31'd0, gp_latch}, 32'd0);
        snap();
        wb_rd(2'd0, rd); check("abort_csr_idle", rd, 32'h0000_0000);
        repeat (300) @(negedge clk);
        wb_rd(2'd1, rd); check("abort_pads01", rd, 32'h0000_0000);
        wb_rd(2'd3, rd); check("abort_scan_cnt", rd, 32'd0);
        check("abort_no_restart", m_lrise - b_lrise, 32'd0);

        // Auto-poll every 2^POLL_TW cycles
        do_reset();
        raw[0] = 16'hFFFF; raw[1] = 16'hFFFF;
        wb_wr(2'd0, 32'h1);
        wb_rd(2'd0, rd); check("autopoll_csr", rd, 32'h0000_0001);
        repeat (1024) @(negedge clk);
        wb_wr(2'd0, 32'h0);
        wait_idle();
        wb_rd(2'd3, rd);
`ifdef GAMEPAD_MULTITAP_EN
        check("autopoll_cnt_in_1_3", {31'd0, (rd >= 1 && rd <= 3)}, 32'd1);
`else
        check("autopoll_cnt_in_3_5", {31'd0, (rd >= 3 && rd <= 5)}, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gamepad_wb.md
GAMEPAD_WB -- requirements
Module: gamepad_wb

Interface
REQ-001 SHALL have parameter DIV, default 8: gp_clk half-period in clk cycles; legal range 2..255.
REQ-002 SHALL have parameter POLL_TW, default 18: auto-poll period is 2^POLL_TW clk cycles.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk input 1 (system clock); rst input 1 (synchronous, active-high).
REQ-004 SHALL have gp_latch output 1 (controller latch strobe) and gp_clk output 1 (controller shift clock, idles high).
REQ-005 SHALL have gp_sel output 1 (controller bank select) and gp_data input 2 (serial data from pad 0 and pad 1, active-low).
REQ-006 SHALL have wb_addr input 2, wb_wdata input 32, wb_rdata output 32, wb_we input 1, wb_cyc input 1, wb_ack output 1.

Function
REQ-007 Bus handshake SHALL be: wb_ack = 1 exactly one cycle after wb_cyc rises, held for one cycle, and never on two consecutive cycles.
REQ-008 wb_rdata SHALL be 0 whenever wb_ack = 0, and SHALL carry registered read data on the ack cycle.
REQ-009 Register map SHALL be:
- addr 0 CSR: bit0 autopoll_en (RW); bit1 busy (RO); write bit2 = 1 starts a scan (self-clearing, reads 0).
- addr 1: {pad1[15:0], pad0[15:0]} (RO).
- addr 2: {pad3, pad2} (RO).
- addr 3: scan_cnt[15:0] in the low half, 0 in the high half (RO).
REQ-010 FSM states SHALL be IDLE, LATCH, GAP, LOW, HIGH, DONE.
- IDLE -> LATCH on trigger or auto-poll tick.
- LATCH: gp_latch = 1 for 2*DIV cycles.
- GAP: gp_latch = 0, gp_clk = 1 for DIV cycles; sample bit 0 on the last cycle.
- LOW then HIGH: each DIV cycles, with gp_clk 0 then 1; sample bit k on the last HIGH cycle; repeat for k = 1..15.
- After bit 15 -> DONE (1 cycle) -> IDLE.
REQ-011 One bank pass SHALL last exactly 33*DIV cycles from the first LATCH cycle to the last sample.
REQ-012 Sampled bits SHALL be inverted (1 = pressed) and shifted LSB-first, so that bit k of the pad word = button k.
REQ-013 Pad registers SHALL update atomically in DONE only; a read mid-scan SHALL return the previous complete scan.
REQ-014 scan_cnt SHALL increment by 1 in DONE and wrap from 0xFFFF to 0x0000.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 Trigger or auto-poll tick arriving while busy SHALL be dropped, not queued.
REQ-017 Trigger and tick in the same cycle SHALL start one scan only.
REQ-018 The auto-poll counter SHALL free-run regardless of autopoll_en; the tick SHALL fire on counter wrap only if autopoll_en = 1.
REQ-019 A write to addr 1..3 SHALL be acked and otherwise ignored.

Reset
REQ-020 On rst the block SHALL go to IDLE with gp_latch = 0, gp_clk = 1, gp_sel = 0, wb_ack = 0, wb_rdata = 0, autopoll_en = 0, all pad registers 0, scan_cnt 0, and poll counter 0.
REQ-021 rst asserted mid-scan SHALL abort the scan on the next edge, with no pad register update and no scan_cnt increment.

Configuration
REQ-022 The macro GAMEPAD_MULTITAP_EN SHALL select multitap support.
- Defined: each scan SHALL run two bank passes back to back, first with gp_sel = 0 (pads 0/1) and then gp_sel = 1 (pads 2/3); gp_sel SHALL change only in IDLE or between passes while gp_latch = 0.
- Defined: all four pad registers SHALL update together in the final DONE, and the total scan SHALL be 66*DIV + 1 cycles.
- Undefined: gp_sel SHALL be held at 0, addr 2 SHALL read 0, and only one pass SHALL run per scan.

Verification
REQ-023 Reset check: DIV=4, read CSR right after reset -> rdata 0x00000000; gp_clk = 1; gp_latch = 0.
REQ-024 Single scan: DIV=4, write CSR = 0x4, pad0 model presents 0xFFFE (button 0 pressed) and pad1 0x7FFF -> gp_latch high for 8 cycles; 16 samples in 132 cycles; addr 1 reads 0x80000001; addr 3 reads 1.
REQ-025 Busy drop: trigger again 10 cycles into a scan -> busy = 1, no second scan, scan_cnt = 1 after completion.
REQ-026 Auto-poll: POLL_TW=8, CSR = 0x1 -> scans start every 256 cycles; after 1024 cycles scan_cnt = 4 (±1).
REQ-027 Reset mid-scan: rst during bit 7 of a scan with pad0 = 0x0000 -> addr 1 stays at its prior value; FSM in IDLE; gp_clk = 1.
REQ-028 Multitap (macro defined): pads 2/3 model 0xFFF0 and 0x0FFF -> gp_sel 0 then 1; addr 2 reads 0xF000000F; total scan 265 cycles at DIV=4.
